serv_mtimer: RTL and testbench

- RISC-V machine timer (mtime/mtimecmp) for a SERV-based SoC.
- Sits directly upstream of the CSR unit and drives its machine-timer-pending input (`i_mtip`).
- Software accesses the timer through a 32-bit Wishbone slave port.
- The CSR unit gates `o_mtip` with mstatus.MIE/mie.MTIE and edge-detects it into a new IRQ, so this block only has to hold a level.

---
 rtl/serv_mtimer.sv | 139 +++++++++++++
 tb/tb_serv_mtimer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/serv_mtimer.sv
// serv_mtimer: RISC-V machine timer (mtime/mtimecmp) behind a 32-bit Wishbone slave.
// Optional 16-bit tick prescaler at word address 4, enabled by defining SERV_MTIMER_PRESCALE_EN.
module serv_mtimer #(
    parameter logic [63:0] CMP_RST   = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter logic [63:0] MTIME_RST = 64'h0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_we,
    input  logic [2:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_mtip
);
    localparam logic [2:0] ADR_MTIME_LO = 3'd0;
    localparam logic [2:0] ADR_MTIME_HI = 3'd1;
    localparam logic [2:0] ADR_CMP_LO   = 3'd2;
    localparam logic [2:0] ADR_CMP_HI   = 3'd3;
    localparam logic [2:0] ADR_PRESCALE = 3'd4;

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        mtip_q, mtip_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] rdata;
    logic        access, wr, rd, tick;

    // Byte-lane merge of write data into an existing 32-bit word.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdat,
                                          input logic [3:0] sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) res[8*i +: 8] = sel[i] ? wdat[8*i +: 8] : old[8*i +: 8];
        return res;
    endfunction

    // An access starts on any request cycle that is not itself the ack cycle.
    assign access = i_wb_cyc & ~ack_q;
    assign wr     = access & i_wb_we;
    assign rd     = access & ~i_wb_we;

`ifdef SERV_MTIMER_PRESCALE_EN
    logic [15:0] pre_q, pre_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] pre_merged;

    assign pre_merged = merge({16'h0, pre_q}, i_wb_dat, i_wb_sel);
    assign tick       = (cnt_q == pre_q);

    // Prescaler: reload on tick or on a PRESCALE write, otherwise count up.
    always_comb begin
        pre_d = pre_q;
        cnt_d = tick ? 16'h0 : cnt_q + 16'd1;
        if (wr && i_wb_adr == ADR_PRESCALE) begin
            pre_d = pre_merged[15:0];
            cnt_d = 16'h0;
        end
    end

    // Prescaler state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_q <= 16'h0;
            cnt_q <= 16'h0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Read mux over the register map; MTIME_HI returns the shadow captured by the LO read.
    always_comb begin
        rdata = 32'h0;
        case (i_wb_adr)
            ADR_MTIME_LO: rdata = mtime_q[31:0];
            ADR_MTIME_HI: rdata = shadow_q;
            ADR_CMP_LO:   rdata = cmp_q[31:0];
            ADR_CMP_HI:   rdata = cmp_q[63:32];
`ifdef SERV_MTIMER_PRESCALE_EN
            ADR_PRESCALE: rdata = {16'h0, pre_q};
`endif
            default:      rdata = 32'h0;
        endcase
    end

    // Next-state: bus handshake, writes (which override the tick), shadow and compare.
    always_comb begin
        ack_d    = access;
        dat_d    = access ? rdata : dat_q;
        mtime_d  = mtime_q;
        cmp_d    = cmp_q;
        shadow_d = shadow_q;
        if (wr && i_wb_adr == ADR_MTIME_LO)
            mtime_d[31:0] = merge(mtime_q[31:0], i_wb_dat, i_wb_sel);
        else if (wr && i_wb_adr == ADR_MTIME_HI)
            mtime_d[63:32] = merge(mtime_q[63:32], i_wb_dat, i_wb_sel);
        else if (tick)
            mtime_d = mtime_q + 64'd1;
        if (wr && i_wb_adr == ADR_CMP_LO)
            cmp_d[31:0] = merge(cmp_q[31:0], i_wb_dat, i_wb_sel);
        if (wr && i_wb_adr == ADR_CMP_HI)
            cmp_d[63:32] = merge(cmp_q[63:32], i_wb_dat, i_wb_sel);
        if (rd && i_wb_adr == ADR_MTIME_LO)
            shadow_d = mtime_q[63:32];
        else if (wr && i_wb_adr == ADR_MTIME_HI)
            shadow_d = mtime_d[63:32];
        mtip_d = (mtime_q >= cmp_q);
    end

    // Timer and bus state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_q    <= 1'b0;
            dat_q    <= 32'h0;
            mtip_q   <= 1'b0;
            mtime_q  <= MTIME_RST;
            cmp_q    <= CMP_RST;
            shadow_q <= 32'h0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            mtip_q   <= mtip_d;
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            shadow_q <= shadow_d;
        end
    end

    assign o_wb_ack = ack_q;
    assign o_wb_dat = dat_q;
    assign o_mtip   = mtip_q;
endmodule

// File: tb/tb_serv_mtimer.sv
// tb_serv_mtimer: directed Wishbone vectors with hand-computed expectations for serv_mtimer.
module tb_serv_mtimer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  adr = 3'd0;
    logic [31:0] wdat = 32'h0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] o_wb_dat;
    logic        o_wb_ack;
    logic        o_mtip;
    logic [31:0] r;
    int          n_vec = 0;
    int          n_err = 0;

    serv_mtimer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_we(we), .i_wb_adr(adr),
        .i_wb_dat(wdat), .i_wb_sel(sel), .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack), .o_mtip(o_mtip)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wb(input logic w, input logic [2:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] q);
        @(posedge clk); #1;
        cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (o_wb_ack) break;
        end
        check("ack", {63'h0, o_wb_ack}, 64'h1);
        q = o_wb_dat;
        cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wb_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] q;
        wb(1'b1, a, d, s, q);
    endtask

    task automatic wb_rd(input logic [2:0] a, output logic [31:0] q);
        wb(1'b0, a, 32'h0, 4'h0, q);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {63'h0, o_wb_ack}, 64'h0);
        check("rst_dat", {32'h0, o_wb_dat}, 64'h0);
        check("rst_mtip", {63'h0, o_mtip}, 64'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(posedge clk);
        wb_rd(3'd0, r);
        check("idle_lo", {32'h0, r}, 64'd11);
        check("idle_mtip", {63'h0, o_mtip}, 64'h0);

        wb_wr(3'd3, 32'h0, 4'hF);
        wb_wr(3'd0, 32'h30, 4'hF);
        wb_wr(3'd2, 32'h40, 4'hF);
        repeat (13) @(posedge clk);
        @(posedge clk); #1;
        check("mtip_pre", {63'h0, o_mtip}, 64'h0);
        @(posedge clk); #1;
        check("mtip_rise", {63'h0, o_mtip}, 64'h1);
        wb_wr(3'd2, 32'hFFFF_FFFF, 4'hF);
        check("mtip_hold", {63'h0, o_mtip}, 64'h1);
        @(posedge clk); #1;
        check("mtip_fall", {63'h0, o_mtip}, 64'h0);

        wb_wr(3'd0, 32'hFFFF_FFFE, 4'hF);
        wb_wr(3'd1, 32'h0, 4'hF);
        repeat (3) @(posedge clk);
        wb_rd(3'd0, r);
        check("carry_lo", {32'h0, r}, 64'h3);
        wb_rd(3'd1, r);
        check("carry_hi", {32'h0, r}, 64'h1);

        wb_wr(3'd2, 32'h0, 4'hF);
        wb_rd(3'd2, r);
        check("cmp_lo_rb", {32'h0, r}, 64'h0);
        wb_wr(3'd1, 32'hFFFF_FFFF, 4'hF);
        wb_wr(3'd0, 32'hFFFF_FFFF, 4'hF);
        wb_rd(3'd0, r);
        check("wrap_lo", {32'h0, r}, 64'h0);
        check("wrap_mtip", {63'h0, o_mtip}, 64'h1);
        wb_rd(3'd1, r);
        check("wrap_hi", {32'h0, r}, 64'h0);
        wb_wr(3'd1, 32'h77, 4'hF);
        wb_rd(3'd1, r);
        check("shadow_wr", {32'h0, r}, 64'h77);

        wb_wr(3'd0, 32'h0, 4'hF);
        wb_wr(3'd0, 32'h1234_5678, 4'b0010);
        wb_rd(3'd0, r);
        check("sel_lo", {32'h0, r}, 64'h5602);

        wb_wr(3'd2, 32'hA5A5_5A5A, 4'hF);
        @(posedge clk); #1;
        cyc = 1'b1; we = 1'b0; adr = 3'd2;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            check("b2b_ack", {63'h0, o_wb_ack}, {63'h0, i[0]});
            if (i[0]) check("b2b_dat", {32'h0, o_wb_dat}, 64'hA5A5_5A5A);
        end
        cyc = 1'b0;
        wb_wr(3'd5, 32'hFFFF_FFFF, 4'hF);
        wb_rd(3'd5, r);
        check("adr5", {32'h0, r}, 64'h0);
`ifndef SERV_MTIMER_PRESCALE_EN
        wb_wr(3'd4, 32'h3, 4'hF);
        wb_rd(3'd4, r);
        check("adr4", {32'h0, r}, 64'h0);
`endif

        wb_wr(3'd2, 32'h0, 4'hF);
        wb_rd(3'd0, r);
        check("pre_rst_mtip", {63'h0, o_mtip}, 64'h1);
        @(posedge clk); #1;
        cyc = 1'b1; we = 1'b1; adr = 3'd0; wdat = 32'hDEAD_BEEF; sel = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        check("arst_ack", {63'h0, o_wb_ack}, 64'h0);
        check("arst_mtip", {63'h0, o_mtip}, 64'h0);
        check("arst_dat", {32'h0, o_wb_dat}, 64'h0);
        cyc = 1'b0; we = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        wb_rd(3'd0, r);
        check("arst_lo", {32'h0, r}, 64'h1);
        check("arst_mtip2", {63'h0, o_mtip}, 64'h0);

`ifdef SERV_MTIMER_PRESCALE_EN
        wb_wr(3'd0, 32'h0, 4'hF);
        wb_wr(3'd4, 32'h3, 4'hF);
        wb_rd(3'd0, r);
        check("ps_0", {32'h0, r}, 64'h2);
        wb_rd(3'd0, r);
        check("ps_1", {32'h0, r}, 64'h2);
        wb_rd(3'd0, r);
        check("ps_2", {32'h0, r}, 64'h3);
        wb_rd(3'd0, r);
        check("ps_3", {32'h0, r}, 64'h3);
        wb_rd(3'd0, r);
        check("ps_4", {32'h0, r}, 64'h4);
        wb_rd(3'd4, r);
        check("ps_rb", {32'h0, r}, 64'h3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
